pc_unit: RTL and testbench

//   Program-counter unit for the MIPS core: owns the PC register, picks the next PC among

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_target_calc.sv | 64 ++++++
 rtl/pc_unit.sv | 149 ++++++++++++++
 tb/tb_pc_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and encodings for the program-counter unit.
//   XLEN_DEF          default PC / data width
//   RESET_VECTOR_DEF  default PC after reset
//   EXC_VECTOR_DEF    default exception vector
//   pc_src_e          next-PC source encoding
//   more_than_one()   true when two or more bits of a 5-bit flag vector are set
package pc_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_JR   = 3'd3,
    SRC_EXC  = 3'd4,
    SRC_PEND = 3'd5
  } pc_src_e;

  // Clearing the lowest set bit leaves something only if a second bit was set.
  function automatic logic more_than_one(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect-target generation.
//   pc         in   current PC
//   imm26      in   instr[25:0]; branch offset is imm26[15:0]
//   rs_hi      in   rs operand bits [XLEN-1:2] (jr target, low bits forced to 0)
//   j/jal/jr/beq/bne/zero  in  decoded control flags and ALU zero
//   pc_plus4   out  pc + 4
//   target     out  highest-priority taken target (pc_plus4 when nothing taken)
//   src        out  which source produced target (SRC_SEQ when nothing taken)
//   taken      out  some redirect is taken
//   multi_ctrl out  more than one control-flow flag asserted
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     imm26,
  input  logic [XLEN-3:0] rs_hi,
  input  logic            j,
  input  logic            jal,
  input  logic            jr,
  input  logic            beq,
  input  logic            bne,
  input  logic            zero,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output pc_src_e         src,
  output logic            taken,
  output logic            multi_ctrl
);

  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] jr_target;
  logic            br_taken;

  assign pc_plus4   = pc + XLEN'(4);
  // Sign-extended word offset, already shifted left by two.
  assign br_offset  = {{(XLEN-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  assign j_target   = {pc_plus4[XLEN-1:28], imm26, 2'b00};
  assign jr_target  = {rs_hi, 2'b00};
  assign br_taken   = (beq & zero) | (bne & ~zero);
  assign multi_ctrl = more_than_one({j, jal, jr, beq, bne});

  always_comb begin
    src    = SRC_SEQ;
    target = pc_plus4;
    if (jr) begin
      src    = SRC_JR;
      target = jr_target;
    end else if (j | jal) begin
      src    = SRC_J;
      target = j_target;
    end else if (br_taken) begin
      src    = SRC_BR;
      target = br_target;
    end
  end

  assign taken = (src != SRC_SEQ);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: MIPS program-counter unit. Holds the PC, selects the next PC among
// sequential / branch / jump / jr / exception / pending delay-slot redirect.
// Optional feature macro: PC_PERF_EN builds saturating redirect and stall
// counters; without it both counter outputs are tied to zero.
//   i_clk, i_rst_n         clock, async active-low reset
//   i_stall                hold PC and pending redirect
//   i_exc                  go to EXC_VECTOR, beats everything including stall
//   i_j/i_jal/i_jr/i_beq/i_bne/i_zero/i_imm26/i_rs_data  control of instr at o_pc
//   o_pc, o_pc_plus4, o_link   current PC, PC+4, jal link value
//   o_redirect             taken redirect decided this cycle
//   o_ctrl_err             conflicting control flags or control flow in a delay slot
//   o_jr_misalign          jr target with nonzero low bits
//   o_redirect_cnt, o_stall_cnt  performance counters
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF),
  parameter int              DELAY_SLOT   = 0,
  parameter int              CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_exc,
  input  logic             i_j,
  input  logic             i_jal,
  input  logic             i_jr,
  input  logic             i_beq,
  input  logic             i_bne,
  input  logic             i_zero,
  input  logic [25:0]      i_imm26,
  input  logic [XLEN-1:0]  i_rs_data,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic [XLEN-1:0]  o_link,
  output logic             o_redirect,
  output logic             o_ctrl_err,
  output logic             o_jr_misalign,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam bit DS = (DELAY_SLOT != 0);

  logic [XLEN-1:0] pc_q;
  logic            pend_valid_q;
  logic [XLEN-1:0] pend_target_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] calc_target;
  pc_src_e         calc_src;
  logic            calc_taken;
  logic            multi_ctrl;
  logic            any_ctrl;
  logic            in_slot;
  logic            pend_set;
  pc_src_e         next_src;
  logic [XLEN-1:0] pc_next;

  pc_target_calc #(.XLEN(XLEN)) u_calc (
    .pc         (pc_q),
    .imm26      (i_imm26),
    .rs_hi      (i_rs_data[XLEN-1:2]),
    .j          (i_j),
    .jal        (i_jal),
    .jr         (i_jr),
    .beq        (i_beq),
    .bne        (i_bne),
    .zero       (i_zero),
    .pc_plus4   (pc_plus4),
    .target     (calc_target),
    .src        (calc_src),
    .taken      (calc_taken),
    .multi_ctrl (multi_ctrl)
  );

  // A valid pending redirect means the instruction at o_pc is the delay slot.
  assign in_slot  = DS & pend_valid_q;
  assign any_ctrl = i_j | i_jal | i_jr | i_beq | i_bne;

  always_comb begin
    next_src = SRC_SEQ;
    pend_set = 1'b0;
    if (i_exc) begin
      next_src = SRC_EXC;
    end else if (in_slot) begin
      next_src = SRC_PEND;
    end else if (calc_taken) begin
      if (DS) pend_set = 1'b1;   // slot instruction runs first
      else    next_src = calc_src;
    end
  end

  always_comb begin
    case (next_src)
      SRC_EXC:                 pc_next = EXC_VECTOR;
      SRC_PEND:                pc_next = pend_target_q;
      SRC_BR, SRC_J, SRC_JR:   pc_next = calc_target;
      default:                 pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (i_exc) begin
      pc_q          <= pc_next;
      pend_valid_q  <= 1'b0;
    end else if (!i_stall) begin
      pc_q          <= pc_next;
      pend_valid_q  <= pend_set;
      if (pend_set) pend_target_q <= calc_target;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_plus4;
  assign o_link        = DS ? (pc_q + XLEN'(8)) : pc_plus4;
  assign o_redirect    = i_exc | (~i_stall & calc_taken & ~in_slot);
  assign o_ctrl_err    = multi_ctrl | (in_slot & any_ctrl);
  assign o_jr_misalign = i_jr & (i_rs_data[1:0] != 2'b00);

`ifdef PC_PERF_EN
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // o_redirect already includes i_exc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (o_redirect && !(&redirect_cnt_q)) redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      if (i_stall && !(&stall_cnt_q))       stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_redirect_cnt = redirect_cnt_q;
  assign o_stall_cnt    = stall_cnt_q;
`else
  assign o_redirect_cnt = '0;
  assign o_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: bench for pc_unit. Two instances share all inputs:
// u_dut0 (no delay slot, 16-bit counters) and u_dut1 (delay slot, 2-bit
// counters). A behavioural model tracks both; directed steps also check
// literal addresses. Honours PC_PERF_EN for counter expectations.
module tb_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0, i_exc = 1'b0;
  logic        i_j = 1'b0, i_jal = 1'b0, i_jr = 1'b0, i_beq = 1'b0, i_bne = 1'b0, i_zero = 1'b0;
  logic [25:0] i_imm26 = '0;
  logic [31:0] i_rs_data = '0;

  logic [31:0] pc0, p40, lk0, pc1, p41, lk1;
  logic        rd0, er0, ms0, rd1, er1, ms1;
  logic [15:0] rc0, sc0;
  logic [1:0]  rc1, sc1;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [31:0] m_pc [2];
  logic        m_pv;
  logic [31:0] m_pt;
  int          m_rc [2];
  int          m_sc [2];
  // Model next state / comb expectations
  logic [31:0] n_pc [2];
  logic        n_pv;
  logic [31:0] n_pt;
  logic        e_redir [2];
  logic        e_err [2];
  logic [31:0] e_link [2];
  logic        e_mis;
  const int    cnt_max [2] = '{65535, 3};

  always #5 i_clk = ~i_clk;

  pc_unit #(.DELAY_SLOT(0), .CNT_W(16)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_exc(i_exc),
    .i_j(i_j), .i_jal(i_jal), .i_jr(i_jr), .i_beq(i_beq), .i_bne(i_bne),
    .i_zero(i_zero), .i_imm26(i_imm26), .i_rs_data(i_rs_data),
    .o_pc(pc0), .o_pc_plus4(p40), .o_link(lk0), .o_redirect(rd0),
    .o_ctrl_err(er0), .o_jr_misalign(ms0), .o_redirect_cnt(rc0), .o_stall_cnt(sc0)
  );

  pc_unit #(.DELAY_SLOT(1), .CNT_W(2)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_exc(i_exc),
    .i_j(i_j), .i_jal(i_jal), .i_jr(i_jr), .i_beq(i_beq), .i_bne(i_bne),
    .i_zero(i_zero), .i_imm26(i_imm26), .i_rs_data(i_rs_data),
    .o_pc(pc1), .o_pc_plus4(p41), .o_link(lk1), .o_redirect(rd1),
    .o_ctrl_err(er1), .o_jr_misalign(ms1), .o_redirect_cnt(rc1), .o_stall_cnt(sc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_stall = 0; i_exc = 0; i_j = 0; i_jal = 0; i_jr = 0;
    i_beq = 0; i_bne = 0; i_zero = 0; i_imm26 = '0; i_rs_data = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_rc[k] = 0; m_sc[k] = 0;
    end
    m_pv = 0; m_pt = '0;
  endtask

  // Next PC and comb outputs from the architectural rules.
  task automatic model_comb();
    int nflags;
    logic taken, slot;
    logic [31:0] p4, tgt, off;
    nflags = int'(i_j) + int'(i_jal) + int'(i_jr) + int'(i_beq) + int'(i_bne);
    taken  = i_jr | i_j | i_jal | (i_beq & i_zero) | (i_bne & ~i_zero);
    e_mis  = i_jr && (i_rs_data % 4 != 0);
    n_pv = m_pv; n_pt = m_pt;
    for (int k = 0; k < 2; k++) begin
      p4  = m_pc[k] + 32'd4;
      off = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
      if (i_jr)            tgt = i_rs_data & ~32'd3;
      else if (i_j | i_jal) tgt = (p4 & 32'hF000_0000) | ({6'd0, i_imm26} * 4);
      else                 tgt = p4 + off;
      slot = (k == 1) && m_pv;
      e_redir[k] = i_exc || (!i_stall && taken && !slot);
      e_err[k]   = (nflags > 1) || (slot && nflags > 0);
      e_link[k]  = m_pc[k] + ((k == 1) ? 32'd8 : 32'd4);
      if (i_exc) begin
        n_pc[k] = 32'h8000_0180;
        if (k == 1) n_pv = 0;
      end else if (i_stall) begin
        n_pc[k] = m_pc[k];
      end else if (slot) begin
        n_pc[k] = m_pt; n_pv = 0;
      end else if (taken && k == 0) begin
        n_pc[k] = tgt;
      end else begin
        n_pc[k] = p4;
        if (taken) begin n_pv = 1; n_pt = tgt; end
      end
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = n_pc[k];
      if (e_redir[k] && m_rc[k] < cnt_max[k]) m_rc[k]++;
      if (i_stall && m_sc[k] < cnt_max[k])   m_sc[k]++;
    end
    m_pv = n_pv; m_pt = n_pt;
  endtask

  task automatic chk_cnt();
    int er0c, es0c, er1c, es1c;
`ifdef PC_PERF_EN
    er0c = m_rc[0]; es0c = m_sc[0]; er1c = m_rc[1]; es1c = m_sc[1];
`else
    er0c = 0; es0c = 0; er1c = 0; es1c = 0;
`endif
    chk("rcnt0", {16'd0, rc0}, er0c);
    chk("scnt0", {16'd0, sc0}, es0c);
    chk("rcnt1", {30'd0, rc1}, er1c);
    chk("scnt1", {30'd0, sc1}, es1c);
  endtask

  // One cycle: check comb outputs against the model, clock, check PCs.
  task automatic step();
    #1;
    model_comb();
    chk("plus4_0", p40, m_pc[0] + 32'd4);
    chk("plus4_1", p41, m_pc[1] + 32'd4);
    chk("redir0", {31'd0, rd0}, {31'd0, e_redir[0]});
    chk("redir1", {31'd0, rd1}, {31'd0, e_redir[1]});
    chk("err0", {31'd0, er0}, {31'd0, e_err[0]});
    chk("err1", {31'd0, er1}, {31'd0, e_err[1]});
    chk("mis0", {31'd0, ms0}, {31'd0, e_mis});
    chk("mis1", {31'd0, ms1}, {31'd0, e_mis});
    chk("link0", lk0, e_link[0]);
    chk("link1", lk1, e_link[1]);
    @(posedge i_clk);
    #1;
    model_commit();
    chk("pc0", pc0, m_pc[0]);
    chk("pc1", pc1, m_pc[1]);
    chk_cnt();
  endtask

  task automatic mid_reset();
    @(posedge i_clk);
    #3 i_rst_n = 0;
    #1;
    model_reset();
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_pc1", pc1, 32'h0);
    chk_cnt();
    #2 i_rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr();
    model_reset();
    // 1: reset, then sequential fetch
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1;
    #1;
    chk("t1_pc_rst", pc0, 32'h0);
    step(); chk("t1_pc4", pc0, 32'h4);
    step(); chk("t1_pc8", pc0, 32'h8);
    step(); chk("t1_pcC", pc0, 32'hC);
    mid_reset();

    // 2: beq taken backwards / not taken
    i_jr = 1; i_rs_data = 32'h100; step(); clr();
    chk("t2_at100", pc0, 32'h100);
    i_beq = 1; i_zero = 1; i_imm26 = 26'h000_FFFE; step(); clr();
    chk("t2_beq_taken", pc0, 32'h0FC);
    i_jr = 1; i_rs_data = 32'h100; step(); clr();
    i_beq = 1; i_zero = 0; i_imm26 = 26'h000_FFFE; step(); clr();
    chk("t2_beq_not", pc0, 32'h104);

    // 3: j and misaligned jr
    i_jr = 1; i_rs_data = 32'h1000_0000; step(); clr();
    i_j = 1; i_imm26 = 26'h40; step(); clr();
    chk("t3_j", pc0, 32'h1000_0100);
    i_jr = 1; i_rs_data = 32'h2003;
    #1 chk("t3_misalign", {31'd0, ms0}, 32'd1);
    step(); clr();
    chk("t3_jr", pc0, 32'h2000);

    // 4: stall beats jump, exception beats stall
    i_jr = 1; i_rs_data = 32'h200; step(); clr();
    for (int i = 0; i < 3; i++) begin
      i_stall = 1; i_j = 1; i_imm26 = 26'h3;
      step();
      chk("t4_hold", pc0, 32'h200);
    end
    clr();
    i_stall = 1; i_exc = 1; step(); clr();
    chk("t4_exc0", pc0, 32'h8000_0180);
    chk("t4_exc1", pc1, 32'h8000_0180);

    // 5: delay slot behaviour on u_dut1
    i_jr = 1; i_rs_data = 32'h40; step(); clr();
    step();
    chk("t5_at40", pc1, 32'h40);
    i_stall = 1; i_jal = 1; i_imm26 = 26'h123;
    #1 chk("t5_link", lk1, 32'h48);
    step(); clr();
    chk("t5_stall_hold", pc1, 32'h40);
    i_bne = 1; i_zero = 0; i_imm26 = 26'h4; step(); clr();
    chk("t5_slot", pc1, 32'h44);
    step();
    chk("t5_target", pc1, 32'h54);
    i_bne = 1; i_imm26 = 26'h4; step(); clr();
    chk("t5_slot2", pc1, 32'h58);
    i_stall = 1; step(); step(); clr();
    chk("t5_slot_held", pc1, 32'h58);
    i_j = 1; i_imm26 = 26'h7;
    #1 chk("t5_slot_err", {31'd0, er1}, 32'd1);
    step(); clr();
    chk("t5_pend_target", pc1, 32'h68);

    // 6: counters, including 2-bit saturation on u_dut1
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      i_j = 1; i_imm26 = 26'(i * 16); step();
    end
    clr();
    i_stall = 1; step(); step();
`ifdef PC_PERF_EN
    chk("t6_rcnt", {16'd0, rc0}, 32'd5);
    chk("t6_scnt", {16'd0, sc0}, 32'd2);
`else
    chk("t6_rcnt_off", {16'd0, rc0}, 32'd0);
    chk("t6_scnt_off", {16'd0, sc0}, 32'd0);
`endif
    step(); step(); step(); clr();
`ifdef PC_PERF_EN
    chk("t6_rcnt_sat", {30'd0, rc1}, 32'd3);
    chk("t6_scnt_sat", {30'd0, sc1}, 32'd3);
`else
    chk("t6_rcnt1_off", {30'd0, rc1}, 32'd0);
    chk("t6_scnt1_off", {30'd0, sc1}, 32'd0);
`endif

    // Random traffic against the model
    mid_reset();
    for (int n = 0; n < 400; n++) begin
      clr();
      i_stall   = ($urandom % 4) == 0;
      i_exc     = ($urandom % 20) == 0;
      i_zero    = $urandom % 2;
      i_imm26   = 26'($urandom);
      i_rs_data = $urandom;
      case ($urandom % 8)
        2: i_j   = 1;
        3: i_jal = 1;
        4: i_jr  = 1;
        5: i_beq = 1;
        6: i_bne = 1;
        7: {i_j, i_jal, i_jr, i_beq, i_bne} = 5'($urandom);
        default: ;
      endcase
      step();
    end
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
